// File: rtl/sect571k1_pkg.sv
// Shared constants and FSM state type for the sect571k1 point-multiplier
// arbiter slice.
package sect571k1_pkg;

    localparam int M               = 571;
    localparam int DEFAULT_TIMEOUT = 2000000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        ABORT,
        RESP
    } state_t;

endpackage

// File: rtl/sect571k1_rr_arb.sv
// Combinational round-robin picker: grants the first valid requester found
// searching upward from ptr+1 with wrap-around.
module sect571k1_rr_arb #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id,
    output logic            any
);

    logic [IDW-1:0] idx;

    // NOTE: every output of this block gets a default before the search loop,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                id         = idx;
            end
        end
    end

endmodule

// File: rtl/sect571k1_pt_mul_arb.sv
// Shares one sect571k1_pt_mul core among NREQ requesters: round-robin accept,
// core sequencing with watchdog abort, d==0 bypass, tagged response channel.
module sect571k1_pt_mul_arb
    import sect571k1_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    parameter  int TO_W    = 24,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*M-1:0] req_d,

    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [IDW-1:0]  resp_id,
    output logic [M-1:0]    resp_x,
    output logic [M-1:0]    resp_y,
    output logic            resp_inf,
    output logic            resp_err,

    output logic            core_rst_n,
    output logic            core_clr,
    output logic            core_start,
    output logic [M-1:0]    core_d,
    input  logic            core_done,
    input  logic [M-1:0]    core_x,
    input  logic [M-1:0]    core_y,

    output logic            busy
);

    state_t          state, state_next;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic [IDW-1:0]  ptr;
    logic [TO_W-1:0] wd;
    logic [M-1:0]    sel_d;
    logic            wd_expired;

    sect571k1_rr_arb #(.NREQ(NREQ)) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .id    (grant_id),
        .any   (grant_any)
    );

    assign sel_d      = req_d[int'(grant_id)*M +: M];
    assign wd_expired = (wd == TO_W'(TIMEOUT - 1));

    // The core is held in reset for exactly as long as this block is.
    assign core_rst_n = ~rst;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_any && !rst) begin
                    req_ready  = grant;
                    state_next = (sel_d == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: state_next = BUSY;
            BUSY: begin
                if (core_done)       state_next = RESP;
                else if (wd_expired) state_next = ABORT;
            end
            ABORT: state_next = RESP;
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pulse/level outputs are registered from the next state so they line up
    // with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= IDW'(NREQ - 1);
            wd         <= '0;
            busy       <= 1'b0;
            core_start <= 1'b0;
            core_clr   <= 1'b0;
            core_d     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_x     <= '0;
            resp_y     <= '0;
            resp_inf   <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            busy       <= (state_next != IDLE);
            core_start <= (state_next == ISSUE);
            core_clr   <= (state_next == ABORT);
            resp_valid <= (state_next == RESP);
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        ptr     <= grant_id;
                        resp_id <= grant_id;
                        if (sel_d == '0) begin
                            resp_x   <= '0;
                            resp_y   <= '0;
                            resp_inf <= 1'b1;
                            resp_err <= 1'b0;
                        end else begin
                            core_d <= sel_d;
                        end
                    end
                end
                ISSUE: wd <= '0;
                BUSY: begin
                    wd <= wd + 1'b1;
                    if (core_done) begin
                        resp_x   <= core_x;
                        resp_y   <= core_y;
                        resp_inf <= 1'b0;
                        resp_err <= 1'b0;
                        core_d   <= '0;
                    end else if (wd_expired) begin
                        core_d <= '0;
                    end
                end
                ABORT: begin
                    resp_x   <= '0;
                    resp_y   <= '0;
                    resp_inf <= 1'b0;
                    resp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sect571k1_pt_mul_arb.sv
// Bench for sect571k1_pt_mul_arb: behavioural core (x=d+1, y=d+2, done 50
// cycles after start), directed vectors, corner sequences, random traffic.
module tb_sect571k1_pt_mul_arb;
    import sect571k1_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 100;
    localparam int LAT  = 50;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*M-1:0] req_d;
    logic              resp_valid, resp_ready, resp_inf, resp_err;
    logic [IDW-1:0]    resp_id;
    logic [M-1:0]      resp_x, resp_y;
    logic              core_rst_n, core_clr, core_start, core_done, busy;
    logic [M-1:0]      core_d, core_x, core_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sect571k1_pt_mul_arb #(.NREQ(NREQ), .TIMEOUT(TMO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_d(req_d),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_x(resp_x), .resp_y(resp_y), .resp_inf(resp_inf), .resp_err(resp_err),
        .core_rst_n(core_rst_n), .core_clr(core_clr), .core_start(core_start),
        .core_d(core_d), .core_done(core_done), .core_x(core_x), .core_y(core_y),
        .busy(busy)
    );

    // Behavioural core: done pulses in the LAT-th cycle after the start cycle.
    bit         hang = 1'b0;
    logic       spur_done = 1'b0;
    logic       model_done = 1'b0;
    logic [M-1:0] model_x = '0, model_y = '0, lat_d = '0;
    bit         pending = 1'b0;
    int         cnt = 0;
    int         start_cnt = 0;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (!core_rst_n || core_clr) begin
            pending <= 1'b0;
        end else if (core_start) begin
            pending <= 1'b1;
            cnt     <= 1;
            lat_d   <= core_d;
        end else if (pending) begin
            if (cnt == LAT - 1 && !hang) begin
                model_done <= 1'b1;
                pending    <= 1'b0;
                model_x    <= lat_d + M'(1);
                model_y    <= lat_d + M'(2);
            end
            cnt <= cnt + 1;
        end
    end

    always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

    assign core_done = model_done | spur_done;
    assign core_x    = model_x;
    assign core_y    = model_y;

    task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [M-1:0] rand_d();
        logic [M-1:0] r = '0;
        if ($urandom_range(0, 3) == 0) return '0;
        for (int w = 0; w < 18; w++) r = {r[M-33:0], 32'($urandom())};
        return r;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"},  req_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_id"},    resp_id, 0);
        check({tag, "_resp_x"},     resp_x, 0);
        check({tag, "_resp_y"},     resp_y, 0);
        check({tag, "_resp_inf"},   resp_inf, 0);
        check({tag, "_resp_err"},   resp_err, 0);
        check({tag, "_core_clr"},   core_clr, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_core_d"},     core_d, 0);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_core_rst_n"}, core_rst_n, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; resp_ready = 1'b0; spur_done = 1'b0; hang = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_resp(output int n);
        n = 1;
        while (!resp_valid && n < 400) begin
            tick();
            n++;
        end
        check("resp_arrives", resp_valid, 1);
    endtask

    task automatic run_single(input int req, input logic [M-1:0] d, input logic [M-1:0] x,
                              input logic [M-1:0] y, input logic inf, input string name);
        int n, s0;
        req_valid = '0;
        req_valid[req] = 1'b1;
        req_d[req*M +: M] = d;
        #1;
        check({name, "_ready"}, req_ready, 1 << req);
        s0 = start_cnt;
        tick();
        req_valid = '0;
        if (d != '0) begin
            check({name, "_start"}, core_start, 1);
            check({name, "_core_d"}, core_d, d);
        end
        wait_resp(n);
        check({name, "_latency"}, n, (d != '0) ? 2 + LAT : 1);
        check({name, "_starts"}, start_cnt - s0, (d != '0) ? 1 : 0);
        check({name, "_id"},  resp_id, req);
        check({name, "_x"},   resp_x, x);
        check({name, "_y"},   resp_y, y);
        check({name, "_inf"}, resp_inf, inf);
        check({name, "_err"}, resp_err, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({name, "_drop"}, resp_valid, 0);
        check({name, "_idle"}, busy, 0);
    endtask

    typedef struct {
        int           req;
        logic [M-1:0] d;
        logic [M-1:0] x;
        logic [M-1:0] y;
        logic         inf;
    } vec_t;

    typedef struct {
        int           id;
        logic [M-1:0] x;
        logic [M-1:0] y;
        logic         inf;
    } exp_t;

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        int   n;
        int   fair_exp[5];
        int   gq[$];
        int   rq_id[$];
        logic [M-1:0] rq_x[$];
        int   nresp;

        tbl[0] = '{2, M'(5), M'(6), M'(7), 1'b0};
        tbl[1] = '{1, M'(0), M'(0), M'(0), 1'b1};
        tbl[2] = '{3, {M{1'b1}}, M'(0), M'(1), 1'b0};
        tbl[3] = '{0, {1'b1, {(M-1){1'b0}}}, {1'b1, {(M-2){1'b0}}, 1'b1},
                   {1'b1, {(M-3){1'b0}}, 2'b10}, 1'b0};
        fair_exp = '{0, 1, 2, 3, 0};
        req_d = '0;

        do_reset();

        for (int i = 0; i < 4; i++)
            run_single(tbl[i].req, tbl[i].d, tbl[i].x, tbl[i].y, tbl[i].inf, $sformatf("vec%0d", i));

        // All requesters continuously valid from reset: strict rotation.
        do_reset();
        for (int i = 0; i < NREQ; i++) req_d[i*M +: M] = M'(i + 10);
        req_valid = '1;
        resp_ready = 1'b1;
        #1;
        nresp = 0;
        for (int c = 0; c < 600 && nresp < 5; c++) begin
            if (req_ready != '0) gq.push_back(oh2i(req_ready));
            if (resp_valid) begin
                rq_id.push_back(int'(resp_id));
                rq_x.push_back(resp_x);
                nresp++;
            end
            if (nresp < 5) tick();
        end
        tick();
        req_valid = '0;
        resp_ready = 1'b0;
        check("fair_grant_count", gq.size(), 5);
        check("fair_resp_count", rq_id.size(), 5);
        for (int k = 0; k < 5 && k < gq.size(); k++)
            check($sformatf("fair_grant%0d", k), gq[k], fair_exp[k]);
        for (int k = 0; k < 5 && k < rq_id.size(); k++) begin
            check($sformatf("fair_resp_id%0d", k), rq_id[k], fair_exp[k]);
            check($sformatf("fair_resp_x%0d", k), rq_x[k], M'(fair_exp[k] + 11));
        end
        tick();

        // Core never answers: BUSY lasts TMO cycles, then a single clear pulse.
        hang = 1'b1;
        req_valid = 4'b0010;
        req_d[1*M +: M] = M'(9);
        tick();
        req_valid = '0;
        check("tmo_start", core_start, 1);
        n = 0;
        while (!core_clr && n < 300) begin
            tick();
            n++;
        end
        check("tmo_clr_delay", n, TMO + 1);
        tick();
        check("tmo_clr_single", core_clr, 0);
        check("tmo_resp_valid", resp_valid, 1);
        check("tmo_err", resp_err, 1);
        check("tmo_inf", resp_inf, 0);
        check("tmo_x", resp_x, 0);
        check("tmo_y", resp_y, 0);
        check("tmo_id", resp_id, 1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        hang = 1'b0;
        run_single(3, M'(100), M'(101), M'(102), 1'b0, "after_tmo");

        // Response back-pressure with another requester waiting.
        req_valid = 4'b0001;
        req_d[0*M +: M] = M'(20);
        tick();
        req_valid = '0;
        wait_resp(n);
        req_valid = 4'b1000;
        req_d[3*M +: M] = M'(77);
        for (int c = 0; c < 20; c++) begin
            #1;
            check("bp_valid", resp_valid, 1);
            check("bp_x", resp_x, M'(21));
            check("bp_y", resp_y, M'(22));
            check("bp_id", resp_id, 0);
            check("bp_no_grant", req_ready, 0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check("bp_exit_no_grant", req_ready, 0);
        tick();
        resp_ready = 1'b0;
        check("bp_dropped", resp_valid, 0);
        check("bp_next_grant", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        wait_resp(n);
        check("bp_next_id", resp_id, 3);
        check("bp_next_x", resp_x, M'(78));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset while BUSY: transaction vanishes, late done is ignored.
        req_valid = 4'b0100;
        req_d[2*M +: M] = M'(33);
        tick();
        req_valid = '0;
        repeat (10) tick();
        check("rstb_busy", busy, 1);
        rst = 1'b1;
        tick();
        check_zero("rstb");
        rst = 1'b0;
        tick();
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (resp_valid || busy || core_clr) n++;
            tick();
        end
        check("rstb_silent", n, 0);

        // Random traffic against a transaction-level model.
        begin
            bit           v[NREQ];
            logic [M-1:0] dd[NREQ];
            exp_t         q[$];
            exp_t         e;
            bit           outstanding = 1'b0;
            int           last = NREQ - 1;
            int           issued = 0, jobs = 0, cyc = 0;
            int           g;
            logic [NREQ-1:0] exp_g;
            logic         rv;

            do_reset();
            for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
            while ((jobs < 40 || outstanding) && cyc < 20000) begin
                rv = resp_valid;
                for (int i = 0; i < NREQ; i++) begin
                    if (!v[i] && issued < 40 && $urandom_range(0, 3) == 0) begin
                        v[i] = 1'b1;
                        dd[i] = rand_d();
                    end else if (v[i] && $urandom_range(0, 31) == 0) begin
                        v[i] = 1'b0;
                    end
                    req_valid[i] = v[i];
                    req_d[i*M +: M] = dd[i];
                end
                resp_ready = 1'($urandom_range(0, 1));
                #1;
                exp_g = '0;
                g = -1;
                if (!outstanding) begin
                    for (int k = 1; k <= NREQ; k++)
                        if (g < 0 && v[(last + k) % NREQ]) g = (last + k) % NREQ;
                    if (g >= 0) exp_g[g] = 1'b1;
                end
                check("rand_grant", req_ready, exp_g);
                if (g >= 0) begin
                    e.id  = g;
                    e.inf = (dd[g] == '0);
                    e.x   = e.inf ? '0 : dd[g] + M'(1);
                    e.y   = e.inf ? '0 : dd[g] + M'(2);
                    q.push_back(e);
                    v[g] = 1'b0;
                    last = g;
                    outstanding = 1'b1;
                    issued++;
                end
                if (rv && resp_ready) begin
                    if (q.size() == 0) begin
                        check("rand_unexpected_resp", resp_valid, 0);
                    end else begin
                        e = q.pop_front();
                        check("rand_id", resp_id, e.id);
                        check("rand_x", resp_x, e.x);
                        check("rand_y", resp_y, e.y);
                        check("rand_inf", resp_inf, e.inf);
                        check("rand_err", resp_err, 0);
                        jobs++;
                    end
                    outstanding = 1'b0;
                end
                tick();
                cyc++;
            end
            req_valid = '0;
            resp_ready = 1'b0;
            check("rand_jobs_done", jobs, issued);
            check("rand_min_jobs", jobs >= 40, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
